// File: rtl/sram_pkg.sv
// Shared types for the SRAM bank: FSM encoding, request direction constants and byte parity.
package sram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // Even parity: the stored bit makes the 9-bit lane's ones-count even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sram_bank_ctrl_if.sv
// Request/response bus of the SRAM bank. The master drives requests and the slave answers them.
// A request transfers on a rising edge where Req_Valid and Req_Ready are both high. Req_Ready may
// depend combinationally on the slave's inputs, but it never depends on Req_Valid. Rd_Valid is a
// one-cycle pulse, and Data_Out holds its value until the next accepted read.
interface sram_bank_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
);
  localparam int BE_W = DATA_W / 8;

  logic              Req_Valid;
  logic              Req_Ready;
  logic              Req_RW;
  logic [ADDR_W-1:0] Req_Addr;
  logic [DATA_W-1:0] Req_Data;
  logic [BE_W-1:0]   Req_BE;
  logic              Rd_Valid;
  logic [DATA_W-1:0] Data_Out;

  modport master (
    output Req_Valid, Req_RW, Req_Addr, Req_Data, Req_BE,
    input  Req_Ready, Rd_Valid, Data_Out
  );

  modport slave (
    input  Req_Valid, Req_RW, Req_Addr, Req_Data, Req_BE,
    output Req_Ready, Rd_Valid, Data_Out
  );
endinterface

// File: rtl/sram_array.sv
// Single-port storage with per-lane write enables and a registered read port.
// The storage itself is never reset. Only the read register is reset.
module sram_array #(
  parameter int LANE_W = 8,
  parameter int NLANES = 4,
  parameter int ADDR_W = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     re,
  input  logic [NLANES-1:0]        be,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [LANE_W*NLANES-1:0] wdata,
  output logic [LANE_W*NLANES-1:0] rdata
);
  localparam int W     = LANE_W * NLANES;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NLANES; i++) begin
        if (be[i]) mem_q[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/sram_bank_ctrl.sv
// SRAM bank controller: handshake, clear-sweep FSM and read-valid generation around sram_array.
// Optional per-byte parity storage and checking is enabled with `SRAM_PARITY_EN.
module sram_bank_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic             Clk,
  input  logic             Rst,
  sram_bank_ctrl_if.slave  bus,
  input  logic             Clr,
  output logic             Busy,
  output logic             Clr_Done,
  output logic             Parity_Err,
  output state_t           Dbg_State
);
  localparam int BE_W = DATA_W / 8;
`ifdef SRAM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam int MEM_W = LANE_W * BE_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              busy_q, clr_done_q, clr_done_d, rd_valid_q;

  logic              mem_we, mem_re;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata, mem_rdata, req_wdata;
  logic [DATA_W-1:0] data_out;
  logic              accept;

  assign bus.Req_Ready = (state_q == ST_IDLE) & ~Clr;
  assign accept        = bus.Req_Valid & bus.Req_Ready;

`ifdef SRAM_PARITY_EN
  logic [BE_W-1:0] par_bad;
`endif

  // Lane i of a stored word is {parity, byte} with parity, or just the byte without it.
  always_comb begin
    req_wdata = '0;
    data_out  = '0;
`ifdef SRAM_PARITY_EN
    par_bad   = '0;
`endif
    for (int i = 0; i < BE_W; i++) begin
      req_wdata[i*LANE_W +: 8] = bus.Req_Data[i*8 +: 8];
      data_out[i*8 +: 8]       = mem_rdata[i*LANE_W +: 8];
`ifdef SRAM_PARITY_EN
      req_wdata[i*LANE_W + 8]  = byte_parity(bus.Req_Data[i*8 +: 8]);
      par_bad[i] = mem_rdata[i*LANE_W + 8] ^ byte_parity(mem_rdata[i*LANE_W +: 8]);
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    clr_done_d = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_be     = bus.Req_BE;
    mem_addr   = bus.Req_Addr;
    mem_wdata  = req_wdata;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_be    = '1;
        mem_addr  = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == '1) begin
          clr_done_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (Clr) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end else if (accept) begin
          mem_we = (bus.Req_RW == RW_WRITE);
          mem_re = (bus.Req_RW == RW_READ);
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= '0;
      busy_q     <= 1'b1;
      clr_done_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      busy_q     <= (state_d == ST_CLEAR);
      clr_done_q <= clr_done_d;
      rd_valid_q <= mem_re;
    end
  end

  sram_array #(
    .LANE_W (LANE_W),
    .NLANES (BE_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (Clk),
    .rst   (Rst),
    .we    (mem_we),
    .re    (mem_re),
    .be    (mem_be),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign bus.Rd_Valid = rd_valid_q;
  assign bus.Data_Out = data_out;
  assign Busy         = busy_q;
  assign Clr_Done     = clr_done_q;
  assign Dbg_State    = state_q;
`ifdef SRAM_PARITY_EN
  assign Parity_Err   = rd_valid_q & (|par_bad);
`else
  assign Parity_Err   = 1'b0;
`endif
endmodule
